flit_packetizer: RTL and testbench

// - Transmit side of the flit FIFO: serializes one packet (header + N body words) into HEAD/BODY/TAIL flits.
// - Drives a FIFO push port with a valid/ready handshake at up to 1 flit/cycle.
// - Sits between a router/NI packet source and the per-port flit FIFO.

---
 rtl/flit_packetizer.sv | 99 +++++++++
 tb/tb_flit_packetizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_packetizer.sv
// Flit packetizer: turns a header + N body words into HEAD/BODY/TAIL flits
// on a registered valid/ready push port toward the per-port flit FIFO.
module flit_packetizer #(
  parameter int FLIT_W   = 64,
  parameter int HDR_W    = 32,
  parameter int LEN_W    = 4,
  parameter int MAX_BODY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [HDR_W-1:0]  pkt_header,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              body_valid,
  output logic              body_ready,
  input  logic [FLIT_W-3:0] body_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              busy,
  output logic              len_err
);

  localparam int PW = FLIT_W - 2;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  state_t           state;
  logic [7:0]       pkt_id;
  logic [LEN_W-1:0] remaining;

  logic          load_ok;
  logic          pkt_fire;
  logic          body_fire;
  logic          len_bad;
  logic          last_word;
  logic [PW-1:0] head_pl;

  assign load_ok    = !flit_valid || flit_ready;
  assign pkt_ready  = (state == IDLE) && load_ok;
  assign body_ready = (state == BODY) && load_ok;
  assign pkt_fire   = pkt_valid && pkt_ready;
  assign body_fire  = body_valid && body_ready;
  assign len_bad    = pkt_len > LEN_W'(MAX_BODY);
  assign last_word  = remaining == LEN_W'(1);
  assign busy       = state != IDLE;

  always_comb begin
    head_pl                   = '0;
    head_pl[PW-1 -: 8]        = pkt_id;
    head_pl[PW-9 -: LEN_W]    = pkt_len;
    head_pl[HDR_W-1:0]        = pkt_header;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pkt_id     <= '0;
      remaining  <= '0;
      flit_valid <= 1'b0;
      flit_out   <= '0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (pkt_fire && len_bad) begin
        // oversized descriptor is consumed but produces no flit
        len_err <= 1'b1;
        if (flit_ready) flit_valid <= 1'b0;
      end else if (pkt_fire) begin
        flit_valid <= 1'b1;
        pkt_id     <= pkt_id + 8'd1;
        if (pkt_len == '0) begin
          flit_out <= {T_HT, head_pl};
        end else begin
          flit_out  <= {T_HEAD, head_pl};
          remaining <= pkt_len;
          state     <= BODY;
        end
      end else if (body_fire) begin
        flit_valid <= 1'b1;
        flit_out   <= {last_word ? T_TAIL : T_BODY, body_data};
        remaining  <= remaining - LEN_W'(1);
        if (last_word) state <= IDLE;
      end else if (flit_ready) begin
        flit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized bench for flit_packetizer: a queue-based packet model predicts
// every flit, handshake readiness, busy and len_err.
module tb_flit_packetizer;

  localparam int FW = 64;
  localparam int HW = 32;
  localparam int LW = 4;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_valid = 1'b0;
  logic          pkt_ready;
  logic [HW-1:0] pkt_header = '0;
  logic [LW-1:0] pkt_len = '0;
  logic          body_valid = 1'b0;
  logic          body_ready;
  logic [FW-3:0] body_data = '0;
  logic          flit_valid;
  logic          flit_ready = 1'b1;
  logic [FW-1:0] flit_out;
  logic          busy;
  logic          len_err;

  flit_packetizer #(
    .FLIT_W(FW), .HDR_W(HW), .LEN_W(LW), .MAX_BODY(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_header(pkt_header), .pkt_len(pkt_len),
    .body_valid(body_valid), .body_ready(body_ready),
    .body_data(body_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_out(flit_out), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_head(input logic [1:0] t,
      input logic [7:0] id, input logic [3:0] len, input logic [31:0] h);
    logic [63:0] f;
    f = '0;
    f[63:62] = t;
    f[61:54] = id;
    f[53:50] = len;
    f[31:0]  = h;
    return f;
  endfunction

  // reference model state
  logic [63:0] expq[$];
  logic [63:0] e_flit;
  logic [63:0] held;
  logic [7:0]  m_id = '0;
  int          m_rem = 0;
  bit          err_pend = 0;
  bit          stall_prev = 0;
  int          cyc = 0;
  int          pop_cyc[$];
  int          tail_cyc = -1;
  int          acc_cyc = -2;
  int          rdy_mode = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: flit_ready = 1'b1;
      1: flit_ready = ($urandom_range(0, 3) != 0);
      default: flit_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("busy", busy, m_rem != 0);
      chk("len_err", len_err, err_pend);
      chk("pkt_ready", pkt_ready,
          m_rem == 0 && (!flit_valid || flit_ready));
      chk("body_ready", body_ready,
          m_rem != 0 && (!flit_valid || flit_ready));
      if (stall_prev) begin
        chk("hold_valid", flit_valid, 1'b1);
        chk("hold_data", flit_out, held);
      end
      stall_prev = flit_valid && !flit_ready;
      held = flit_out;
      if (flit_valid && flit_ready) begin
        if (expq.size() == 0) begin
          chk("extra_flit", flit_valid, 1'b0);
        end else begin
          e_flit = expq.pop_front();
          chk("flit", flit_out, e_flit);
          pop_cyc.push_back(cyc);
          if (e_flit[63:62] == 2'b10) tail_cyc = cyc;
        end
      end
      err_pend = 0;
      if (pkt_valid && pkt_ready) begin
        acc_cyc = cyc;
        if (int'(pkt_len) > MB) begin
          err_pend = 1;
        end else if (pkt_len == 0) begin
          expq.push_back(mk_head(2'b11, m_id, pkt_len, pkt_header));
          m_id++;
        end else begin
          expq.push_back(mk_head(2'b00, m_id, pkt_len, pkt_header));
          m_id++;
          m_rem = int'(pkt_len);
        end
      end
      if (body_valid && body_ready && m_rem > 0) begin
        expq.push_back({(m_rem == 1) ? 2'b10 : 2'b01, body_data});
        m_rem--;
      end
    end
  end

  // entered and left at posedge+2
  task automatic send_pkt(input logic [31:0] h, input int len,
                          input int gap_pct);
    int n;
    pkt_valid = 1'b1;
    pkt_header = h;
    pkt_len = LW'(len);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pkt_ready && n < 1000);
    if (n >= 1000) chk("pkt_timeout", pkt_ready, 1'b1);
    @(posedge clk);
    #2;
    pkt_valid = 1'b0;
    if (len >= 1 && len <= MB) begin
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 99) < gap_pct) begin
          body_valid = 1'b0;
          @(posedge clk);
          #2;
        end
        body_valid = 1'b1;
        body_data = 62'({$urandom(), $urandom()});
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!body_ready && n < 1000);
        if (n >= 1000) chk("body_timeout", body_ready, 1'b1);
        @(posedge clk);
        #2;
      end
      body_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #17;
    chk("rst_valid", flit_valid, 1'b0);
    chk("rst_out", flit_out, 64'd0);
    chk("rst_err", len_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    send_pkt(32'hCAFE_0001, 0, 0);
    drain();

    pop_cyc.delete();
    send_pkt(32'h1234_5678, 3, 0);
    drain();
    chk("consec", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

    fork
      send_pkt(32'h0000_BEEF, 6, 0);
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    send_pkt(32'hDEAD_0009, 9, 0);
    send_pkt(32'h0000_0A0A, 0, 0);
    drain();

    for (int i = 0; i < 257; i++) send_pkt(32'(i), 0, 0);
    drain();

    send_pkt(32'h0000_00B2, 2, 0);
    send_pkt(32'h0000_00B3, 0, 0);
    chk("tail_b2b", 64'(acc_cyc), 64'(tail_cyc));
    drain();

    for (int i = 0; i < 60; i++) begin
      rdy_mode = $urandom_range(0, 1);
      send_pkt($urandom(), $urandom_range(0, 10), 30);
    end
    rdy_mode = 0;
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #2;
    pkt_valid = 1'b1;
    pkt_header = 32'h0000_0444;
    pkt_len = 4'd4;
    @(posedge clk);
    #2;
    pkt_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", flit_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    expq.delete();
    m_id = '0;
    m_rem = 0;
    err_pend = 0;
    stall_prev = 0;
    rdy_mode = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_pkt(32'h0000_0555, 2, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
